// File: rtl/calc_op_sequencer_if.sv
// Command handshake between the middleware and the calculator execution stage.
// The master issues opcode/operand under valid; the slave answers with ready.
interface calc_op_sequencer_if #(
    parameter int n = 16
) ();
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic [n-1:0] cmd_operand;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_operand,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_operand,
        output cmd_ready
    );
endinterface

// File: rtl/calc_op_sequencer.sv
// Accumulator execution stage: single-cycle ALU ops plus an n-cycle shift-add
// multiply, with the accumulator driven straight onto result every clock.
module calc_op_sequencer #(
    parameter int n  = 16,
    parameter int CW = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    calc_op_sequencer_if.slave cmd,
    output logic [n-1:0]       result,
    output logic               result_valid,
    output logic               busy,
    output logic               ovf,
    output logic               zero
);
    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_MUL  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EXEC     = 2'd1,
        MUL_ITER = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [2:0]     op_q;
    logic [n-1:0]   operand_q;
    logic [CW-1:0]  cnt;
    logic [2*n-1:0] partial;
    logic [2*n-1:0] partial_nxt;
    logic [n:0]     alu_res;
    logic           accept;
    logic           mul_last;

    // Bit n of the return value carries the ovf flag (carry or borrow).
    function automatic logic [n:0] alu(input logic [2:0] op,
                                       input logic [n-1:0] a,
                                       input logic [n-1:0] b);
        logic [n:0] r;
        r = '0;
        case (op)
            OP_LOAD: r = {1'b0, b};
            OP_ADD:  r = {1'b0, a} + {1'b0, b};
            OP_SUB:  r = {1'b0, a} - {1'b0, b};
            OP_AND:  r = {1'b0, a & b};
            OP_OR:   r = {1'b0, a | b};
            OP_XOR:  r = {1'b0, a ^ b};
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [2*n-1:0] mul_step(input logic [2*n-1:0] acc2,
                                                input logic [n-1:0]   mcand,
                                                input logic [n-1:0]   mplier,
                                                input logic [CW-1:0]  bitpos);
        logic [n-1:0] sel;
        sel = mplier >> bitpos;
        if (sel[0])
            return acc2 + ({{n{1'b0}}, mcand} << bitpos);
        return acc2;
    endfunction

    assign cmd.cmd_ready = (state == IDLE);
    assign busy          = (state != IDLE);
    assign accept        = cmd.cmd_valid && (state == IDLE);
    assign mul_last      = (state == MUL_ITER) && (cnt == CW'(n - 1));
    assign zero          = (result == '0);
    assign alu_res       = alu(op_q, result, operand_q);
    // result holds throughout a multiply, so it doubles as the multiplicand.
    assign partial_nxt   = mul_step(partial, result, operand_q, cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cmd.cmd_valid) begin
                    if (cmd.cmd_op == OP_MUL)
                        state_nxt = MUL_ITER;
                    else
                        state_nxt = EXEC;
                end
            end
            EXEC:     state_nxt = IDLE;
            MUL_ITER: if (mul_last) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q         <= '0;
            operand_q    <= '0;
            cnt          <= '0;
            partial      <= '0;
            result       <= '0;
            ovf          <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (accept) begin
                op_q      <= cmd.cmd_op;
                operand_q <= cmd.cmd_operand;
                cnt       <= '0;
                partial   <= '0;
            end
            if (state == EXEC) begin
                result       <= alu_res[n-1:0];
                ovf          <= alu_res[n];
                result_valid <= 1'b1;
            end
            if (state == MUL_ITER) begin
                partial <= partial_nxt;
                cnt     <= cnt + CW'(1);
                if (mul_last) begin
                    result       <= partial_nxt[n-1:0];
                    ovf          <= |partial_nxt[2*n-1:n];
                    result_valid <= 1'b1;
                    cnt          <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_calc_op_sequencer.sv
// Scoreboard bench for calc_op_sequencer: directed scenarios followed by
// random commands, predicted by a plain-arithmetic accumulator model.
module tb_calc_op_sequencer;
    localparam int N  = 16;
    localparam int CW = 5;

    typedef struct {
        logic [N-1:0] r;
        logic         o;
        int           acc;
        int           lat;
    } exp_t;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic [N-1:0] result;
    logic         result_valid;
    logic         busy;
    logic         ovf;
    logic         zero;

    int           checks = 0;
    int           errors = 0;
    int           cyc    = 0;
    bit           mon_on = 1'b0;
    exp_t         q[$];
    logic [N-1:0] m_acc  = '0;
    logic [N-1:0] prev   = '0;

    calc_op_sequencer_if #(.n(N)) cmd_if ();

    calc_op_sequencer #(.n(N), .CW(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd          (cmd_if),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .ovf          (ovf),
        .zero         (zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference behaviour: the opcode table applied with wide integer arithmetic.
    function automatic void model_apply(input logic [2:0] op, input logic [N-1:0] b,
                                        output logic [N-1:0] r, output logic o);
        longint unsigned a, x, p;
        a = longint'(m_acc);
        x = longint'(b);
        p = 0;
        o = 1'b0;
        case (op)
            3'd0: p = x;
            3'd1: begin p = a + x; o = (p > 64'hFFFF); end
            3'd2: begin p = a - x; o = (x > a); end
            3'd3: begin p = a * x; o = ((p >> N) != 0); end
            3'd4: p = a & x;
            3'd5: p = a | x;
            3'd6: p = a ^ x;
            default: p = 0;
        endcase
        r = p[N-1:0];
        m_acc = r;
    endfunction

    task automatic send(input logic [2:0] op, input logic [N-1:0] b);
        int   budget;
        exp_t e;
        @(negedge clk);
        cmd_if.cmd_valid   = 1'b1;
        cmd_if.cmd_op      = op;
        cmd_if.cmd_operand = b;
        budget = 0;
        while (!cmd_if.cmd_ready && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (!cmd_if.cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: op %0d never accepted within %0d cycles", op, budget);
            cmd_if.cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        model_apply(op, b, e.r, e.o);
        e.acc = cyc;
        e.lat = (op == 3'd3) ? N : 1;
        q.push_back(e);
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int budget;
        budget = 0;
        while (q.size() != 0 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL completion_timeout: %0d commands outstanding", q.size());
            q.delete();
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (!rst_n) begin
                chk("rst_result", 32'(result), 32'h0);
                chk("rst_result_valid", 32'(result_valid), 32'h0);
                chk("rst_busy", 32'(busy), 32'h0);
                chk("rst_cmd_ready", 32'(cmd_if.cmd_ready), 32'h1);
                chk("rst_zero", 32'(zero), 32'h1);
                chk("rst_ovf", 32'(ovf), 32'h0);
                prev = '0;
            end else begin
                automatic bit   due;
                automatic bit   exp_busy;
                automatic exp_t e;
                due      = (q.size() != 0) && ((cyc - q[0].acc) >= q[0].lat);
                exp_busy = (q.size() != 0) && ((cyc - q[0].acc) < q[0].lat);
                chk("busy", 32'(busy), 32'(exp_busy));
                chk("cmd_ready", 32'(cmd_if.cmd_ready), 32'(!exp_busy));
                chk("result_valid", 32'(result_valid), 32'(due));
                if (due) begin
                    e = q.pop_front();
                    if (result_valid) begin
                        chk("result", 32'(result), 32'(e.r));
                        chk("ovf", 32'(ovf), 32'(e.o));
                        chk("zero", 32'(zero), 32'(e.r == '0));
                    end
                end else begin
                    chk("result_hold", 32'(result), 32'(prev));
                end
                prev = result;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_if.cmd_valid   = 1'b0;
        cmd_if.cmd_op      = 3'd0;
        cmd_if.cmd_operand = '0;

        // Reset pulse mid-cycle, then idle with no commands.
        #3;
        rst_n  = 1'b0;
        mon_on = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_result", 32'(result), 32'h0);

        send(3'd0, 16'h1234);
        send(3'd1, 16'h0F0F);
        wait_idle();
        chk("load_add_result", 32'(result), 32'h2143);
        chk("load_add_ovf", 32'(ovf), 32'h0);

        send(3'd0, 16'hFFFF);
        send(3'd1, 16'h0001);
        wait_idle();
        chk("add_wrap_result", 32'(result), 32'h0000);
        chk("add_wrap_ovf", 32'(ovf), 32'h1);
        chk("add_wrap_zero", 32'(zero), 32'h1);
        send(3'd2, 16'h0001);
        wait_idle();
        chk("sub_borrow_result", 32'(result), 32'hFFFF);
        chk("sub_borrow_ovf", 32'(ovf), 32'h1);
        chk("sub_borrow_zero", 32'(zero), 32'h0);

        send(3'd0, 16'h0100);
        send(3'd3, 16'h0300);
        wait_idle();
        chk("mul_ovf_result", 32'(result), 32'h0000);
        chk("mul_ovf_flag", 32'(ovf), 32'h1);

        // XOR is held valid while the multiply is still running.
        send(3'd0, 16'h0012);
        send(3'd3, 16'h0034);
        send(3'd6, 16'h00FF);
        wait_idle();
        chk("mul_then_xor", 32'(result), 32'h0357);

        send(3'd3, 16'h0000);
        wait_idle();
        chk("mul_zero_result", 32'(result), 32'h0000);
        chk("mul_zero_ovf", 32'(ovf), 32'h0);

        // Reset while the multiply is iterating.
        send(3'd0, 16'h1234);
        wait_idle();
        send(3'd3, 16'h0002);
        repeat (6) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        q.delete();
        m_acc = '0;
        #1;
        chk("midmul_rst_result", 32'(result), 32'h0);
        chk("midmul_rst_busy", 32'(busy), 32'h0);
        chk("midmul_rst_valid", 32'(result_valid), 32'h0);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        send(3'd0, 16'h0005);
        wait_idle();
        chk("after_rst_load", 32'(result), 32'h0005);

        // Random command stream with varying gaps, including back-to-back.
        for (int i = 0; i < 60; i++) begin
            automatic logic [2:0]   op;
            automatic logic [N-1:0] b;
            automatic int           sel;
            op  = 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 9);
            if (sel == 0)
                b = '0;
            else if (sel == 1)
                b = '1;
            else if (sel == 2)
                b = 16'h0001;
            else
                b = N'($urandom);
            send(op, b);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
